// File: rtl/c174_lane_scheduler_if.sv
// Job/result handshake bundle between the vector source and the lane scheduler.
// Both channels are valid/ready: a transfer happens on a rising edge where valid && ready.
interface c174_lane_scheduler_if;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_lane;
   logic [1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_lane, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_lane, out_data
   );
endinterface

// File: rtl/c174_lane_scheduler.sv
// Wear-levelling dispatcher for the four c17 lanes: each job goes to the least-used
// enabled lane, idle lanes see a fixed stress pattern, and the lane result comes back.
module c174_lane_scheduler #(
   parameter int unsigned CNT_W    = 16,
   parameter logic [4:0]  IDLE_PAT = 5'b00000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   c174_lane_scheduler_if.slave bus,
   input  logic [3:0]           i_lane_en,
   output logic [19:0]          o_vec,
   input  logic [7:0]           i_res,
   input  logic                 i_cnt_clr,
   input  logic [1:0]           i_cnt_sel,
   output logic [CNT_W-1:0]     o_cnt_rd
);

   logic [CNT_W-1:0] r_cnt [4];
   logic             r_d_valid;
   logic [1:0]       r_d_lane;
   logic [19:0]      r_vec;
   logic             r_out_valid;
   logic [1:0]       r_out_lane;
   logic [1:0]       r_out_data;

   logic             w_any_en;
   logic             w_s2_free;
   logic             w_s1_adv;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_found;
   logic [1:0]       w_sel;
   logic [CNT_W-1:0] w_min;
   logic [19:0]      w_vec_nxt;
   logic [1:0]       w_lane_res;

   assign w_any_en   = |i_lane_en;
   assign w_s2_free  = !r_out_valid || bus.out_ready;
   assign w_s1_adv   = w_s2_free;
   assign w_in_ready = w_any_en && (!r_d_valid || w_s1_adv);
   assign w_accept   = bus.in_valid && w_in_ready;

   // Strict less-than keeps the lowest index on a tie.
   always_comb begin
      w_sel   = 2'd0;
      w_found = 1'b0;
      w_min   = '1;
      for (int i = 0; i < 4; i++) begin
         if (i_lane_en[i] && (!w_found || (r_cnt[i] < w_min))) begin
            w_found = 1'b1;
            w_min   = r_cnt[i];
            w_sel   = 2'(i);
         end
      end
   end

   always_comb begin
      w_vec_nxt = {4{IDLE_PAT}};
      for (int i = 0; i < 4; i++) begin
         if (w_sel == 2'(i)) begin
            w_vec_nxt[19-5*i -: 5] = bus.in_data;
         end
      end
   end

   always_comb begin
      w_lane_res = 2'b00;
      case (r_d_lane)
         2'd0:    w_lane_res = i_res[7:6];
         2'd1:    w_lane_res = i_res[5:4];
         2'd2:    w_lane_res = i_res[3:2];
         default: w_lane_res = i_res[1:0];
      endcase
   end

   // vec is only rewritten on accept so idle lanes are not toggled between jobs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid <= 1'b0;
         r_d_lane  <= 2'd0;
         r_vec     <= {4{IDLE_PAT}};
      end else if (w_accept) begin
         r_d_valid <= 1'b1;
         r_d_lane  <= w_sel;
         r_vec     <= w_vec_nxt;
      end else if (w_s1_adv) begin
         r_d_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_lane  <= 2'd0;
         r_out_data  <= 2'b00;
      end else if (w_s2_free) begin
         r_out_valid <= r_d_valid;
         if (r_d_valid) begin
            r_out_lane <= r_d_lane;
            r_out_data <= w_lane_res;
         end
      end
   end

   // Clear has priority over the same-edge increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (i_cnt_clr) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (w_accept && (r_cnt[w_sel] != {CNT_W{1'b1}})) begin
         r_cnt[w_sel] <= r_cnt[w_sel] + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_lane  = r_out_lane;
   assign bus.out_data  = r_out_data;
   assign o_vec         = r_vec;
   assign o_cnt_rd      = r_cnt[i_cnt_sel];

endmodule

// File: tb/tb_c174_lane_scheduler.sv
// Directed bench for the lane scheduler with a c17 lane model closing the loop on vec/res.
module tb_c174_lane_scheduler;

   logic clk;
   logic rst_n;

   c174_lane_scheduler_if bus1();
   c174_lane_scheduler_if bus2();

   logic [3:0]  lane_en1, lane_en2;
   logic [19:0] vec1, vec2;
   logic [7:0]  res1, res2;
   logic        cnt_clr1, cnt_clr2;
   logic [1:0]  cnt_sel1, cnt_sel2;
   logic [15:0] cnt_rd1;
   logic [1:0]  cnt_rd2;

   int n_cmp;
   int n_fail;

   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = v;
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign res1 = {c17(vec1[19:15]), c17(vec1[14:10]), c17(vec1[9:5]), c17(vec1[4:0])};
   assign res2 = {c17(vec2[19:15]), c17(vec2[14:10]), c17(vec2[9:5]), c17(vec2[4:0])};

   c174_lane_scheduler #(.CNT_W(16), .IDLE_PAT(5'b00000)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .i_lane_en(lane_en1), .o_vec(vec1),
      .i_res(res1), .i_cnt_clr(cnt_clr1), .i_cnt_sel(cnt_sel1), .o_cnt_rd(cnt_rd1)
   );

   c174_lane_scheduler #(.CNT_W(2), .IDLE_PAT(5'b00000)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .i_lane_en(lane_en2), .o_vec(vec2),
      .i_res(res2), .i_cnt_clr(cnt_clr2), .i_cnt_sel(cnt_sel2), .o_cnt_rd(cnt_rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = 5'd0; bus1.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_data = 5'd0; bus2.out_ready = 1'b1;
      lane_en1 = 4'hF; lane_en2 = 4'b0001;
      cnt_clr1 = 1'b0; cnt_clr2 = 1'b0; cnt_sel1 = 2'd0; cnt_sel2 = 2'd0;
      #12;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (vec1 !== 20'h00000) begin n_fail++; $display("FAIL reset_vec: got %h want 00000", vec1); end
      n_cmp++;
      if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus1.in_ready); end
      n_cmp++;
      if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus1.out_valid); end
      n_cmp++;
      if (cnt_rd1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_rd1); end
   endtask

   task automatic test_back_to_back();
      step();
      bus1.in_valid = 1'b1; bus1.in_data = 5'b11111;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 2) bus1.in_valid = 1'b0;
         n_cmp++;
         if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'(i) || bus1.out_data !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_out[%0d]: got v=%b lane=%0d data=%b want v=1 lane=%0d data=10",
                     i, bus1.out_valid, bus1.out_lane, bus1.out_data, i);
         end
      end
      step();
      n_cmp++;
      if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus1.out_valid); end
      for (int i = 0; i < 4; i++) begin
         cnt_sel1 = 2'(i);
         #1;
         n_cmp++;
         if (cnt_rd1 !== 16'd1) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want 1", i, cnt_rd1); end
      end
   endtask

   task automatic test_zero_job();
      bus1.in_valid = 1'b1; bus1.in_data = 5'b00000;
      step();
      bus1.in_valid = 1'b0;
      n_cmp++;
      if (vec1 !== 20'h00000) begin n_fail++; $display("FAIL zero_vec: got %h want 00000", vec1); end
      step();
      n_cmp++;
      if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'd0 || bus1.out_data !== 2'b00) begin
         n_fail++;
         $display("FAIL zero_out: got v=%b lane=%0d data=%b want v=1 lane=0 data=00",
                  bus1.out_valid, bus1.out_lane, bus1.out_data);
      end
      step();
   endtask

   task automatic test_back_pressure();
      // Counts are 2,1,1,1 here, so the jobs land on lanes 1, 2, 3.
      bus1.out_ready = 1'b0;
      bus1.in_valid = 1'b1; bus1.in_data = 5'b10101;
      step();
      bus1.in_data = 5'b00001;
      n_cmp++;
      if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", bus1.in_ready); end
      step();
      bus1.in_data = 5'b10110;
      n_cmp++;
      if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2: got %b want 0", bus1.in_ready); end
      n_cmp++;
      if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'd1 || bus1.out_data !== 2'b11) begin
         n_fail++;
         $display("FAIL bp_out0: got v=%b lane=%0d data=%b want v=1 lane=1 data=11",
                  bus1.out_valid, bus1.out_lane, bus1.out_data);
      end
      step();
      n_cmp++;
      if (bus1.in_ready !== 1'b0 || vec1 !== 20'h00020 || bus1.out_lane !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_hold: got rdy=%b vec=%h lane=%0d want rdy=0 vec=00020 lane=1",
                  bus1.in_ready, vec1, bus1.out_lane);
      end
      bus1.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", bus1.in_ready); end
      step();
      bus1.in_valid = 1'b0;
      n_cmp++;
      if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'd2 || bus1.out_data !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_out1: got v=%b lane=%0d data=%b want v=1 lane=2 data=01",
                  bus1.out_valid, bus1.out_lane, bus1.out_data);
      end
      step();
      n_cmp++;
      if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'd3 || bus1.out_data !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_out2: got v=%b lane=%0d data=%b want v=1 lane=3 data=10",
                  bus1.out_valid, bus1.out_lane, bus1.out_data);
      end
      step();
      n_cmp++;
      if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus1.out_valid); end
   endtask

   task automatic test_retire();
      cnt_clr1 = 1'b1;
      step();
      cnt_clr1 = 1'b0;
      lane_en1 = 4'b0100;
      bus1.in_valid = 1'b1; bus1.in_data = 5'b11111;
      for (int i = 0; i < 7; i++) begin
         step();
         if (i == 4) bus1.in_valid = 1'b0;
         if (i >= 1 && i <= 5) begin
            n_cmp++;
            if (bus1.out_valid !== 1'b1 || bus1.out_lane !== 2'd2 || bus1.out_data !== 2'b10) begin
               n_fail++;
               $display("FAIL retire_out[%0d]: got v=%b lane=%0d data=%b want v=1 lane=2 data=10",
                        i, bus1.out_valid, bus1.out_lane, bus1.out_data);
            end
         end
      end
      n_cmp++;
      if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL retire_drain: got %b want 0", bus1.out_valid); end
      cnt_sel1 = 2'd2;
      #1;
      n_cmp++;
      if (cnt_rd1 !== 16'd5) begin n_fail++; $display("FAIL retire_cnt2: got %0d want 5", cnt_rd1); end
      cnt_sel1 = 2'd0;
      #1;
      n_cmp++;
      if (cnt_rd1 !== 16'd0) begin n_fail++; $display("FAIL retire_cnt0: got %0d want 0", cnt_rd1); end
      lane_en1 = 4'b0000;
      #1;
      n_cmp++;
      if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL retire_none: got %b want 0", bus1.in_ready); end
      lane_en1 = 4'hF;
   endtask

   task automatic test_saturation();
      bus2.in_valid = 1'b1; bus2.in_data = 5'b10101;
      for (int i = 0; i < 5; i++) step();
      bus2.in_valid = 1'b0;
      #1;
      n_cmp++;
      if (cnt_rd2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", cnt_rd2); end
      bus2.in_valid = 1'b1; cnt_clr2 = 1'b1;
      #1;
      n_cmp++;
      if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_clr_ready: got %b want 1", bus2.in_ready); end
      step();
      bus2.in_valid = 1'b0; cnt_clr2 = 1'b0;
      #1;
      n_cmp++;
      if (cnt_rd2 !== 2'd0) begin n_fail++; $display("FAIL sat_clr_cnt: got %0d want 0", cnt_rd2); end
      step();
      step();
   endtask

   task automatic test_reset_mid();
      bus1.out_ready = 1'b0;
      bus1.in_valid = 1'b1; bus1.in_data = 5'b11111;
      step();
      step();
      bus1.in_valid = 1'b0;
      n_cmp++;
      if (bus1.out_valid !== 1'b1 || vec1 === 20'h00000) begin
         n_fail++;
         $display("FAIL mid_full: got v=%b vec=%h want v=1 vec!=00000", bus1.out_valid, vec1);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus1.out_valid !== 1'b0 || vec1 !== 20'h00000) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b vec=%h want v=0 vec=00000", bus1.out_valid, vec1);
      end
      #3;
      rst_n = 1'b1;
      bus1.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_late[%0d]: got %b want 0", i, bus1.out_valid); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_back_to_back();
      test_zero_job();
      test_back_pressure();
      test_retire();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
